// File: rtl/gpt_ctrl_pkg.sv
// Shared types and defaults for the gpt adder controller.
package gpt_ctrl_pkg;

  localparam int GPT_WIDTH     = 64;
  localparam int GPT_MAX_WORDS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef logic req_id_t;

  // Pick a requester; on contention the round-robin pointer decides.
  function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t prio);
    req_id_t id;
    if (v0 && v1) begin
      id = prio;
    end else if (v1) begin
      id = 1'b1;
    end else begin
      id = 1'b0;
    end
    return id;
  endfunction

endpackage

// File: rtl/gpt_add_ctrl_gpt.sv
// Bitwise generate/propagate/toggle terms of two operands; purely combinational.
module gpt_add_ctrl_gpt #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] t_o
);

  assign g_o = a_i & b_i;
  assign p_o = a_i | b_i;
  assign t_o = a_i ^ b_i;

endmodule

// File: rtl/gpt_add_ctrl.sv
// Two-requester multi-word adder on one shared gpt datapath; results registered, 1-cycle latency.
// Owner ready = !res_valid || res_ready; grant held for the whole transaction.
module gpt_add_ctrl
  import gpt_ctrl_pkg::*;
#(
  parameter int WIDTH     = GPT_WIDTH,
  parameter int MAX_WORDS = GPT_MAX_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             res_last,
  output logic             err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  state_e           state_q, state_d;
  req_id_t          owner_q, owner_d;
  req_id_t          rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  req_id_t          res_id_q, res_id_d;
  logic             res_last_q, res_last_d;
  logic             err_q, err_d;

  req_id_t          gnt_id;
  req_id_t          sel_id;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;
  logic             sel_last;
  logic             sel_ready;
  logic             out_free;
  logic             first;
  logic             accept;
  logic             force_end;
  logic             txn_end;
  logic [CW-1:0]    word_num;
  logic             cin_sel;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] t;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic             cout;

  gpt_add_ctrl_gpt #(
    .WIDTH(WIDTH)
  ) u_gpt (
    .a_i(sel_a),
    .b_i(sel_b),
    .g_o(g),
    .p_o(p),
    .t_o(t)
  );

  // Request selection: in IDLE the arbiter picks, in BUSY the owner is locked.
  always_comb begin
    first     = (state_q == ST_IDLE);
    gnt_id    = rr_pick(req0_valid, req1_valid, rr_q);
    sel_id    = first ? gnt_id : owner_q;
    sel_valid = sel_id ? req1_valid : req0_valid;
    sel_a     = sel_id ? req1_a     : req0_a;
    sel_b     = sel_id ? req1_b     : req0_b;
    sel_cin   = sel_id ? req1_cin   : req0_cin;
    sel_last  = sel_id ? req1_last  : req0_last;
    out_free  = !res_valid_q || res_ready;
    sel_ready = out_free && !rst;
    req0_ready = sel_ready && (sel_id == 1'b0);
    req1_ready = sel_ready && (sel_id == 1'b1);
    accept    = sel_valid && sel_ready;
    word_num  = first ? CW'(1) : cnt_q + CW'(1);
    force_end = accept && !sel_last && (word_num == CW'(MAX_WORDS));
    txn_end   = accept && (sel_last || force_end);
    cin_sel   = first ? sel_cin : carry_q;
  end

  // Ripple carry over the shared gpt terms.
  always_comb begin
    c    = '0;
    c[0] = cin_sel;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = t ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    res_valid_d = res_valid_q && !res_ready;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    res_last_d  = res_last_q;
    err_d       = force_end;

    if (accept) begin
      cnt_d       = word_num;
      carry_d     = cout;
      res_valid_d = 1'b1;
      res_sum_d   = sum;
      res_cout_d  = cout;
      res_id_d    = sel_id;
      res_last_d  = sel_last || force_end;
      if (first) begin
        owner_d = gnt_id;
        rr_d    = ~gnt_id;
      end
      state_d = txn_end ? ST_IDLE : ST_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
      res_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      res_last_q  <= res_last_d;
      err_q       <= err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gpt_add_ctrl.sv
// Directed self-checking bench for gpt_add_ctrl.
module tb_gpt_add_ctrl;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req0_last;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_last;
  logic [63:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_id, res_last, err;
  logic [63:0] res_sum;

  int n_checks;
  int n_errors;

  gpt_add_ctrl #(
    .WIDTH(64),
    .MAX_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req0_cin(req0_cin),
    .req0_last(req0_last),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .req1_cin(req1_cin),
    .req1_last(req1_last),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum(res_sum),
    .res_cout(res_cout),
    .res_id(res_id),
    .res_last(res_last),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [63:0] sum, input logic cout,
                           input logic id, input logic last, input logic e);
    check({tag, "_valid"}, 64'(res_valid), 64'(1'b1));
    check({tag, "_sum"},   res_sum,        sum);
    check({tag, "_cout"},  64'(res_cout),  64'(cout));
    check({tag, "_id"},    64'(res_id),    64'(id));
    check({tag, "_last"},  64'(res_last),  64'(last));
    check({tag, "_err"},   64'(err),       64'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic last);
    req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_last = last;
  endtask

  task automatic drive1(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic last);
    req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_last = last;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    res_ready = 1'b1;
    drive0(1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
    drive1(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

    // Reset state
    #1;
    check("rst_rdy0_pre", 64'(req0_ready), 64'd0);
    step();
    step();
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_sum",   res_sum,        64'd0);
    check("rst_cout",  64'(res_cout),  64'd0);
    check("rst_last",  64'(res_last),  64'd0);
    check("rst_err",   64'(err),       64'd0);
    check("rst_rdy0",  64'(req0_ready), 64'd0);
    check("rst_rdy1",  64'(req1_ready), 64'd0);
    rst = 1'b0;

    // Single word with overflow
    drive0(1'b1, ONES, 64'd1, 1'b0, 1'b1);
    #1;
    check("single_rdy0", 64'(req0_ready), 64'd1);
    step();
    check_res("single", 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

    // Two-word chain on req1; second word's cin is ignored in favour of stored carry
    drive1(1'b1, ONES, 64'd1, 1'b0, 1'b0);
    step();
    check_res("chain_w1", 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive1(1'b1, 64'd0, 64'd0, 1'b0, 1'b1);
    step();
    check_res("chain_w2", 64'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive1(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();
    check("chain_drain", 64'(res_valid), 64'd0);

    // Contention from reset: alternating grants starting with req0
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive0(1'b1, 64'd1,  64'd2,  1'b0, 1'b1);
    drive1(1'b1, 64'd10, 64'd20, 1'b1, 1'b1);
    #1;
    check("cont_rdy0", 64'(req0_ready), 64'd1);
    check("cont_rdy1", 64'(req1_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_res($sformatf("cont%0d", i), (i % 2 == 1) ? 64'd31 : 64'd3, 1'b0,
                1'(i % 2), 1'b1, 1'b0);
      check($sformatf("cont%0d_next_rdy1", i), 64'(req1_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive1(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();

    // Backpressure mid-transaction
    drive0(1'b1, ONES, ONES, 1'b1, 1'b0);
    step();
    check_res("bp_w1", ONES, 1'b1, 1'b0, 1'b0, 1'b0);
    res_ready = 1'b0;
    drive0(1'b1, ONES, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_stall%0d_rdy0", i), 64'(req0_ready), 64'd0);
      step();
      check_res($sformatf("bp_hold%0d", i), ONES, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_rdy0", 64'(req0_ready), 64'd1);
    step();
    check_res("bp_w2", 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd5, 64'd6, 1'b0, 1'b1);
    step();
    check_res("bp_w3", 64'd12, 1'b0, 1'b0, 1'b1, 1'b0);
    drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();
    check("bp_drain", 64'(res_valid), 64'd0);

    // Overrun: four words without last forces an end, fifth starts fresh
    drive0(1'b1, 64'd1, 64'd0, 1'b0, 1'b0);
    step();
    check_res("ovr_w1", 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd2, 64'd0, 1'b1, 1'b0);
    step();
    check_res("ovr_w2", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd3, 64'd0, 1'b0, 1'b0);
    step();
    check_res("ovr_w3", 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, ONES, 64'd1, 1'b0, 1'b0);
    step();
    check_res("ovr_w4", 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive0(1'b1, 64'd7, 64'd0, 1'b0, 1'b0);
    step();
    check_res("ovr_w5", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd0, 64'd0, 1'b0, 1'b1);
    step();
    check_res("ovr_w6", 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();

    // Reset after word 2 of 3, then a clean req1 transaction
    drive0(1'b1, ONES, 64'd1, 1'b0, 1'b0);
    step();
    check_res("rmid_w1", 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
    step();
    check_res("rmid_w2", 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive0(1'b1, 64'd9, 64'd9, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("rmid_rdy0", 64'(req0_ready), 64'd0);
    step();
    check("rmid_valid", 64'(res_valid), 64'd0);
    check("rmid_sum",   res_sum,        64'd0);
    rst = 1'b0;
    drive0(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive1(1'b1, 64'd3, 64'd4, 1'b1, 1'b0);
    #1;
    check("rmid_rdy1", 64'(req1_ready), 64'd1);
    step();
    check_res("rmid_r1w1", 64'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    drive1(1'b1, ONES, 64'd0, 1'b0, 1'b1);
    step();
    check_res("rmid_r1w2", ONES, 1'b0, 1'b1, 1'b1, 1'b0);
    drive1(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step();
    check("rmid_drain", 64'(res_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
